// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART TX peripheral.
// Holds FSM state enum, register addresses and STATUS bit indices.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic [3:0] TX_DATA_ADDR  = 4'b0000;
  localparam logic [3:0] STATUS_ADDR   = 4'b0001;
  localparam logic [3:0] BAUD_DIV_ADDR = 4'b0010;
  localparam logic [3:0] IRQ_EN_ADDR   = 4'b0011;

  localparam int ST_BUSY_BIT  = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_EMPTY_BIT = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_DONE_BIT  = 4;
  localparam int ST_CNT_LSB   = 8;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, extra pointer MSB separates full/empty.
// Ports: clk, rst, push, pop, din -> dout, full, empty, count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  // A push into a full FIFO is fine when a pop frees a slot
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= din;
  end

  assign dout  = r_mem[r_rptr[AW-1:0]];
  assign count = r_wptr - r_rptr;
  assign empty = (r_wptr == r_rptr);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter with TX FIFO.
// Ports: clk, rst, data (inout bus), address, rw, ce -> irq, tx.
module uart_tx_periph
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 87
) (
  input  logic                  clk,
  input  logic                  rst,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic [3:0]            address,
  input  logic                  rw,
  input  logic                  ce,
  output logic                  irq,
  output logic                  tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  w_wr;
  logic                  w_rd;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_reload;
  logic [7:0]            w_dout;
  logic [CW-1:0]         w_count;
  logic [DATA_WIDTH-1:0] w_status;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused_hi;

  tx_state_t   r_state;
  logic [15:0] r_baud_div;
  logic [15:0] r_bit_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        r_irq_en;
  logic        r_done;
  logic        r_ovf;

  assign w_wr        = ce & rw;
  assign w_rd        = ce & ~rw;
  assign w_push      = w_wr & (address == TX_DATA_ADDR);
  assign w_reload    = (r_bit_cnt == 16'd0);
  assign w_unused_hi = ^data[DATA_WIDTH-1:16];

  // Pop from IDLE, or at the end of STOP for back-to-back frames
  assign w_pop = ~w_empty &
    ((r_state == IDLE) |
     ((r_state == STOP) & w_reload));

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (w_push),
    .pop  (w_pop),
    .din  (data[7:0]),
    .dout (w_dout),
    .full (w_full),
    .empty(w_empty),
    .count(w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_tx      <= 1'b1;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state   <= START;
            r_tx      <= 1'b0;
            r_shift   <= w_dout;
            r_bit_cnt <= r_baud_div - 16'd1;
          end
        end
        START: begin
          if (w_reload) begin
            r_state   <= DATA;
            r_tx      <= r_shift[0];
            r_bit_idx <= '0;
            r_bit_cnt <= r_baud_div - 16'd1;
          end else begin
            r_bit_cnt <= r_bit_cnt - 16'd1;
          end
        end
        DATA: begin
          if (w_reload) begin
            r_bit_cnt <= r_baud_div - 16'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[r_bit_idx + 3'd1];
            end
          end else begin
            r_bit_cnt <= r_bit_cnt - 16'd1;
          end
        end
        STOP: begin
          if (w_reload) begin
            if (w_pop) begin
              r_state   <= START;
              r_tx      <= 1'b0;
              r_shift   <= w_dout;
              r_bit_cnt <= r_baud_div - 16'd1;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt - 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Later assignments win: a done set beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud_div <= 16'(DEFAULT_DIV);
      r_irq_en   <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_wr && address == BAUD_DIV_ADDR)
        r_baud_div <= (data[15:0] == 16'd0) ?
          16'd1 : data[15:0];
      if (w_wr && address == IRQ_EN_ADDR)
        r_irq_en <= data[0];
      if (w_wr && address == STATUS_ADDR) begin
        r_done <= 1'b0;
        r_ovf  <= 1'b0;
      end
      if (w_push & w_full & ~w_pop)
        r_ovf <= 1'b1;
      if (r_state == STOP && w_reload && !w_pop)
        r_done <= 1'b1;
    end
  end

  always_comb begin
    w_status = '0;
    w_status[ST_BUSY_BIT]  = (r_state != IDLE);
    w_status[ST_FULL_BIT]  = w_full;
    w_status[ST_EMPTY_BIT] = w_empty;
    w_status[ST_OVF_BIT]   = r_ovf;
    w_status[ST_DONE_BIT]  = r_done;
    w_status[ST_CNT_LSB +: CW] = w_count;
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      STATUS_ADDR:   w_rdata = w_status;
      BAUD_DIV_ADDR: w_rdata[15:0] = r_baud_div;
      IRQ_EN_ADDR:   w_rdata[0] = r_irq_en;
      default:       w_rdata = '0;
    endcase
  end

  assign data = w_rd ? w_rdata : {DATA_WIDTH{1'bz}};
  assign irq  = r_irq_en & r_done;
  assign tx   = r_tx;

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph: directed + random bench for uart_tx_periph.
// Reference model tracks frames by elapsed cycles and a byte queue.
module tb_uart_tx_periph;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rw = 1'b0;
  logic        ce = 1'b0;
  logic [3:0]  addr = '0;
  logic        drv = 1'b0;
  logic [31:0] wdat = '0;
  wire  [31:0] data;
  wire         irq;
  wire         tx;

  assign data = drv ? wdat : 32'bz;

  always #5 clk = ~clk;

  uart_tx_periph dut (
    .clk    (clk),
    .rst    (rst),
    .data   (data),
    .address(addr),
    .rw     (rw),
    .ce     (ce),
    .irq    (irq),
    .tx     (tx)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference model
  logic [7:0]  q[$];
  bit          m_busy;
  logic [7:0]  m_byte;
  int          m_pos;
  int          m_div = 1;
  int          m_baud;
  bit          m_done;
  bit          m_ovf;
  bit          m_irq_en;

  function automatic void m_reset();
    q.delete();
    m_busy   = 0;
    m_pos    = 0;
    m_done   = 0;
    m_ovf    = 0;
    m_irq_en = 0;
    m_baud   = 87;
  endfunction

  function automatic logic m_tx();
    int k;
    if (!m_busy) return 1'b1;
    k = m_pos / m_div;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    logic [31:0] v;
    v = '0;
    if (a == STATUS_ADDR) begin
      v[0]    = m_busy;
      v[1]    = (q.size() == 8);
      v[2]    = (q.size() == 0);
      v[3]    = m_ovf;
      v[4]    = m_done;
      v[11:8] = 4'(q.size());
    end else if (a == BAUD_DIV_ADDR) begin
      v[15:0] = 16'(m_baud);
    end else if (a == IRQ_EN_ADDR) begin
      v[0] = m_irq_en;
    end
    return v;
  endfunction

  function automatic void m_edge(input logic c, input logic r,
                                 input logic [3:0] a,
                                 input logic [31:0] d);
    bit fend;
    bit pop;
    fend = m_busy && (m_pos == 10 * m_div - 1);
    pop  = (!m_busy || fend) && (q.size() > 0);
    if (m_busy) m_pos++;
    if (fend && !pop) m_busy = 0;
    if (pop) begin
      m_byte = q.pop_front();
      m_busy = 1;
      m_pos  = 0;
      m_div  = m_baud;
    end
    if (c && r) begin
      if (a == TX_DATA_ADDR) begin
        if (q.size() < 8) q.push_back(d[7:0]);
        else m_ovf = 1;
      end else if (a == STATUS_ADDR) begin
        m_done = 0;
        m_ovf  = 0;
      end else if (a == BAUD_DIV_ADDR) begin
        m_baud = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
      end else if (a == IRQ_EN_ADDR) begin
        m_irq_en = d[0];
      end
    end
    if (fend && !pop) m_done = 1;
  endfunction

  task automatic post_edge_checks();
    check("tx",  {31'b0, tx},  {31'b0, m_tx()});
    check("irq", {31'b0, irq}, {31'b0, m_irq_en & m_done});
  endtask

  task automatic step(input logic c, input logic r,
                      input logic [3:0] a,
                      input logic [31:0] d);
    ce   = c;
    rw   = r;
    addr = a;
    wdat = d;
    drv  = c & r;
    #4;
    if (c && !r)
      check($sformatf("rd%0d", a), data, m_read(a));
    @(posedge clk);
    m_edge(c, r, a, d);
    #1;
    post_edge_checks();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) rd(STATUS_ADDR);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    ce  = 1'b0;
    rw  = 1'b0;
    drv = 1'b0;
    repeat (n) begin
      @(posedge clk);
      m_reset();
      #1;
      post_edge_checks();
    end
    rst = 1'b0;
  endtask

  initial begin
    int unsigned r;
    logic [31:0] d;

    do_reset(3);
    rd(BAUD_DIV_ADDR);
    rd(STATUS_ADDR);
    rd(IRQ_EN_ADDR);
    rd(TX_DATA_ADDR);
    for (int i = 4; i < 16; i++) rd(4'(i));
    step(1'b0, 1'b0, 4'd0, 32'd0);

    wr(BAUD_DIV_ADDR, 32'd4);
    wr(IRQ_EN_ADDR, 32'd1);
    wr(TX_DATA_ADDR, 32'h55);
    idle(42);
    wr(STATUS_ADDR, 32'd0);
    idle(2);

    wr(BAUD_DIV_ADDR, 32'd2);
    wr(TX_DATA_ADDR, 32'hA1);
    wr(TX_DATA_ADDR, 32'h3C);
    wr(TX_DATA_ADDR, 32'hFF);
    idle(64);
    wr(STATUS_ADDR, 32'd0);
    idle(2);

    wr(BAUD_DIV_ADDR, 32'd100);
    for (int i = 0; i < 10; i++) wr(TX_DATA_ADDR, $urandom);
    idle(3);
    wr(STATUS_ADDR, 32'd0);
    idle(420);
    do_reset(1);
    rd(STATUS_ADDR);
    rd(BAUD_DIV_ADDR);
    idle(60);

    wr(BAUD_DIV_ADDR, 32'hABCD_0000);
    rd(BAUD_DIV_ADDR);
    wr(TX_DATA_ADDR, 32'h0F);
    idle(14);

    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        wr(TX_DATA_ADDR, $urandom);
      end else if (r < 6) begin
        wr(STATUS_ADDR, $urandom);
      end else if (r < 8) begin
        wr(IRQ_EN_ADDR, $urandom);
      end else if (r < 12 && !m_busy && q.size() == 0) begin
        d = ($urandom & 32'hFFFF_0000) |
            $urandom_range(0, 6);
        wr(BAUD_DIV_ADDR, d);
      end else if (r < 25) begin
        rd(4'($urandom_range(0, 15)));
      end else if (r < 35) begin
        step(1'b0, 1'($urandom), 4'($urandom), $urandom);
      end else if (r == 99 && i > 2000) begin
        do_reset(1);
        wr(BAUD_DIV_ADDR, 32'd3);
      end else begin
        rd(STATUS_ADDR);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
